ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Execute stage plus EX/MEM pipeline register of the 5-stage RV64I pipeline, sitting directly downstream of the ID/EX register. It resolves operand forwarding, runs the ALU, evaluates branch conditions, and registers results, memory controls and branch decision for the MEM stage. Its registered branch decision is the flush source for the IF/ID and ID/EX registers.

## Interface
- No parameters; datapath fixed at 64 bits, register index at 5 bits.
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- PC_In, ReadData1_in, ReadData2_in, imm_data_in  in  64 each  from ID/EX
- rs1_in, rs2_in, rd_in  in  5 each  from ID/EX
- Funct_in  in  4  {funct7[5], funct3}
- ALUOp_in  in  2  00 add, 01 branch compare, 10 R/I-type via Funct_in
- f3_in  in  3  branch funct3
- MemtoReg_in, RegWrite_in, Branch_in, MemWrite_in, MemRead_in, ALUSrc_in  in  1 each  controls from ID/EX
- mem_wb_RegWrite  in  1  MEM/WB write enable
- mem_wb_rd  in  5  MEM/WB destination
- mem_wb_data  in  64  MEM/WB writeback value
- ALU_result_out  out  64  registered ALU result
- WriteData_out  out  64  registered forwarded rs2 value (store data)
- rd_out  out  5  registered destination
- MemtoReg_out, RegWrite_out, MemWrite_out, MemRead_out  out  1 each  registered controls
- branch_target_out  out  64  registered PC_In + (imm_data_in << 1)
- flush  out  1  registered branch-taken; drives upstream flush and PC select

## Operation
- Forwarding, operand A (B identical using rs2_in):
  - EX/MEM hazard: RegWrite_out && rd_out != 0 && rd_out == rs1_in && !MemRead_out selects ALU_result_out.
  - Otherwise MEM/WB hazard: mem_wb_RegWrite && mem_wb_rd != 0 && mem_wb_rd == rs1_in selects mem_wb_data.
  - Otherwise ReadData1_in.
  - EX/MEM has priority when both match.
- Forwarded B goes to WriteData; ALU B input = ALUSrc_in ? imm_data_in : forwarded B.
- ALU op decode:
  - ALUOp 00 → ADD; 01 → SUB.
  - ALUOp 10, Funct 0000 → ADD; 1000 → SUB; 0111 → AND; 0110 → OR; 0100 → XOR; 0001 → SLL; 0101 → SRL; 1101 → SRA.
  - Any other Funct → ADD.
  - Shifts use B[5:0]; arithmetic wraps modulo 2^64.
- Branch condition on forwarded A/B:
  - f3 000 → eq; 001 → ne; 100 → signed lt; 101 → signed ge; 110 → unsigned lt; 111 → unsigned ge; other codes → not taken.
  - taken_d = Branch_in && cond && !flush.
- Squash: while flush is high, the instruction in EX is wrong-path. RegWrite, MemWrite, MemRead, MemtoReg and taken_d register as 0; data fields register normally.
- Register update: every cycle (no stall input), outputs load from EX results.
- Reset (synchronous, overrides everything, including mid-branch): every output register, including flush and branch_target_out, is 0 on the next edge.

## Timing
- EX→MEM latency: 1 cycle. Results are visible the cycle after the instruction sits on the inputs.
- flush is high for exactly one cycle per taken branch, the cycle after the branch is in EX. Back-to-back taken branches cannot both flush: the second is squashed by the first.
- Forwarding and ALU are combinational from inputs and registered outputs; no combinational input-to-output path.

## Structure
- Shared package `riscv_pkg`:
  - ALU op enum (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA).
  - ALUOp encodings.
  - Branch funct3 constants.
  - Forward-select enum (NONE, EXMEM, MEMWB).
- One sub-module, `alu64`: op, a, b → 64-bit result. Purely combinational.
- Forwarding, branch compare and pipeline register stay in `ex_mem_stage`.

## Test plan
- **ADD R-type:** A=5, B=7, ALUOp 10, Funct 0000, RegWrite 1, rd 3 → next cycle ALU_result_out=12, rd_out=3, RegWrite_out=1.
- **Forward priority:**
  - Back-to-back `add x1` then `sub x2,x1,x1`: ReadData stale 0, EX/MEM holds x1=9 → result 0 via EX/MEM forwarding.
  - Same, with MEM/WB also holding x1=4 → EX/MEM value still wins.
- **Taken BEQ:** A=B=0x10, Branch 1, f3 000, PC 0x100, imm 8 → flush=1 for one cycle, branch_target_out=0x110. Following instruction, with RegWrite 1, registers with RegWrite_out=0.
- **Not-taken / signed compare:** BLT with A=-1, B=1 → taken. BLTU with the same operands → not taken, flush stays 0.
- **x0 and load guard:**
  - rd_out=0 with RegWrite_out=1 → never forwarded.
  - MemRead_out=1 with matching rd → MEM/WB or register value used.
- **Reset:** assert reset in the same cycle a taken branch registers → all outputs 0 after that edge, and flush never asserts.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64I pipeline definitions: ALU operations, ALUOp encodings,
// branch funct3 codes and forwarding-source selection.
package riscv_pkg;

   // ALU operations implemented by alu64
   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLL = 3'd5,
      ALU_SRL = 3'd6,
      ALU_SRA = 3'd7
   } alu_op_e;

   // ALUOp field coming from the decoder
   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

   // Funct field is {funct7[5], funct3}
   localparam logic [3:0] FN_ADD = 4'b0000;
   localparam logic [3:0] FN_SUB = 4'b1000;
   localparam logic [3:0] FN_AND = 4'b0111;
   localparam logic [3:0] FN_OR  = 4'b0110;
   localparam logic [3:0] FN_XOR = 4'b0100;
   localparam logic [3:0] FN_SLL = 4'b0001;
   localparam logic [3:0] FN_SRL = 4'b0101;
   localparam logic [3:0] FN_SRA = 4'b1101;

   // Branch funct3 codes
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Where an EX operand comes from
   typedef enum logic [1:0] {
      FWD_NONE  = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_e;

   // Map ALUOp/Funct to an ALU operation; anything unrecognised adds.
   function automatic alu_op_e alu_decode(input logic [1:0] alu_op, input logic [3:0] funct);
      alu_op_e op;
      op = ALU_ADD;
      case (alu_op)
         ALUOP_ADD:    op = ALU_ADD;
         ALUOP_BRANCH: op = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  op = ALU_ADD;
               FN_SUB:  op = ALU_SUB;
               FN_AND:  op = ALU_AND;
               FN_OR:   op = ALU_OR;
               FN_XOR:  op = ALU_XOR;
               FN_SLL:  op = ALU_SLL;
               FN_SRL:  op = ALU_SRL;
               FN_SRA:  op = ALU_SRA;
               default: op = ALU_ADD;
            endcase
         end
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu64.sv
// 64-bit combinational ALU; shifts use b[5:0], arithmetic wraps.
module alu64
   import riscv_pkg::*;
(
   input  alu_op_e     op,
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic [63:0] result
);

   logic [5:0] shamt_s;

   assign shamt_s = b[5:0];

   // Compute the selected operation
   always_comb begin
      result = 64'd0;
      case (op)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SLL: result = a << shamt_s;
         ALU_SRL: result = a >> shamt_s;
         ALU_SRA: result = $signed(a) >>> shamt_s;
         default: result = a + b;
      endcase
   end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage plus EX/MEM register: operand forwarding, ALU, branch
// resolution and registration of results and controls for MEM.
module ex_mem_stage
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] PC_In,
   input  logic [63:0] ReadData1_in,
   input  logic [63:0] ReadData2_in,
   input  logic [63:0] imm_data_in,
   input  logic [4:0]  rs1_in,
   input  logic [4:0]  rs2_in,
   input  logic [4:0]  rd_in,
   input  logic [3:0]  Funct_in,
   input  logic [1:0]  ALUOp_in,
   input  logic [2:0]  f3_in,
   input  logic        MemtoReg_in,
   input  logic        RegWrite_in,
   input  logic        Branch_in,
   input  logic        MemWrite_in,
   input  logic        MemRead_in,
   input  logic        ALUSrc_in,
   input  logic        mem_wb_RegWrite,
   input  logic [4:0]  mem_wb_rd,
   input  logic [63:0] mem_wb_data,
   output logic [63:0] ALU_result_out,
   output logic [63:0] WriteData_out,
   output logic [4:0]  rd_out,
   output logic        MemtoReg_out,
   output logic        RegWrite_out,
   output logic        MemWrite_out,
   output logic        MemRead_out,
   output logic [63:0] branch_target_out,
   output logic        flush
);

   // EX/MEM pipeline registers
   logic [63:0] alu_result_q, alu_result_d;
   logic [63:0] write_data_q, write_data_d;
   logic [4:0]  rd_q, rd_d;
   logic        mem_to_reg_q, mem_to_reg_d;
   logic        reg_write_q, reg_write_d;
   logic        mem_write_q, mem_write_d;
   logic        mem_read_q, mem_read_d;
   logic [63:0] branch_target_q, branch_target_d;
   logic        flush_q, flush_d;

   // Execute-stage combinational signals
   fwd_sel_e    fwd_a_s, fwd_b_s;
   logic [63:0] op_a_s, op_b_fwd_s, alu_b_s, alu_res_s;
   logic        cond_s;
   alu_op_e     alu_op_s;

   // Pick operand sources; EX/MEM wins, but a load result is not yet
   // available there, and x0 is never forwarded.
   always_comb begin
      fwd_a_s = FWD_NONE;
      fwd_b_s = FWD_NONE;
      if (reg_write_q && (rd_q != 5'd0) && (rd_q == rs1_in) && !mem_read_q) begin
         fwd_a_s = FWD_EXMEM;
      end else if (mem_wb_RegWrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == rs1_in)) begin
         fwd_a_s = FWD_MEMWB;
      end else begin
         fwd_a_s = FWD_NONE;
      end
      if (reg_write_q && (rd_q != 5'd0) && (rd_q == rs2_in) && !mem_read_q) begin
         fwd_b_s = FWD_EXMEM;
      end else if (mem_wb_RegWrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == rs2_in)) begin
         fwd_b_s = FWD_MEMWB;
      end else begin
         fwd_b_s = FWD_NONE;
      end
   end

   // Operand muxes; the forwarded B value is also the store data
   always_comb begin
      op_a_s     = ReadData1_in;
      op_b_fwd_s = ReadData2_in;
      case (fwd_a_s)
         FWD_EXMEM: op_a_s = alu_result_q;
         FWD_MEMWB: op_a_s = mem_wb_data;
         default:   op_a_s = ReadData1_in;
      endcase
      case (fwd_b_s)
         FWD_EXMEM: op_b_fwd_s = alu_result_q;
         FWD_MEMWB: op_b_fwd_s = mem_wb_data;
         default:   op_b_fwd_s = ReadData2_in;
      endcase
      alu_b_s  = ALUSrc_in ? imm_data_in : op_b_fwd_s;
      alu_op_s = alu_decode(ALUOp_in, Funct_in);
   end

   alu64 u_alu (
      .op     (alu_op_s),
      .a      (op_a_s),
      .b      (alu_b_s),
      .result (alu_res_s)
   );

   // Branch condition on the forwarded register operands
   always_comb begin
      cond_s = 1'b0;
      case (f3_in)
         F3_BEQ:  cond_s = (op_a_s == op_b_fwd_s);
         F3_BNE:  cond_s = (op_a_s != op_b_fwd_s);
         F3_BLT:  cond_s = ($signed(op_a_s) <  $signed(op_b_fwd_s));
         F3_BGE:  cond_s = ($signed(op_a_s) >= $signed(op_b_fwd_s));
         F3_BLTU: cond_s = (op_a_s <  op_b_fwd_s);
         F3_BGEU: cond_s = (op_a_s >= op_b_fwd_s);
         default: cond_s = 1'b0;
      endcase
   end

   // Next register contents; a wrong-path instruction (flush high) keeps
   // its data but loses every side effect, including its own branch.
   always_comb begin
      alu_result_d    = alu_res_s;
      write_data_d    = op_b_fwd_s;
      rd_d            = rd_in;
      branch_target_d = PC_In + (imm_data_in << 1);
      if (flush_q) begin
         mem_to_reg_d = 1'b0;
         reg_write_d  = 1'b0;
         mem_write_d  = 1'b0;
         mem_read_d   = 1'b0;
         flush_d      = 1'b0;
      end else begin
         mem_to_reg_d = MemtoReg_in;
         reg_write_d  = RegWrite_in;
         mem_write_d  = MemWrite_in;
         mem_read_d   = MemRead_in;
         flush_d      = Branch_in && cond_s;
      end
   end

   // EX/MEM register with synchronous reset overriding everything
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_result_q    <= 64'd0;
         write_data_q    <= 64'd0;
         rd_q            <= 5'd0;
         mem_to_reg_q    <= 1'b0;
         reg_write_q     <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_read_q      <= 1'b0;
         branch_target_q <= 64'd0;
         flush_q         <= 1'b0;
      end else begin
         alu_result_q    <= alu_result_d;
         write_data_q    <= write_data_d;
         rd_q            <= rd_d;
         mem_to_reg_q    <= mem_to_reg_d;
         reg_write_q     <= reg_write_d;
         mem_write_q     <= mem_write_d;
         mem_read_q      <= mem_read_d;
         branch_target_q <= branch_target_d;
         flush_q         <= flush_d;
      end
   end

   assign ALU_result_out    = alu_result_q;
   assign WriteData_out     = write_data_q;
   assign rd_out            = rd_q;
   assign MemtoReg_out      = mem_to_reg_q;
   assign RegWrite_out      = reg_write_q;
   assign MemWrite_out      = mem_write_q;
   assign MemRead_out       = mem_read_q;
   assign branch_target_out = branch_target_q;
   assign flush             = flush_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed cases with literal
// expectations, then randomized traffic against a behavioural model.
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] PC_In, ReadData1_in, ReadData2_in, imm_data_in;
   logic [4:0]  rs1_in, rs2_in, rd_in;
   logic [3:0]  Funct_in;
   logic [1:0]  ALUOp_in;
   logic [2:0]  f3_in;
   logic        MemtoReg_in, RegWrite_in, Branch_in, MemWrite_in, MemRead_in, ALUSrc_in;
   logic        mem_wb_RegWrite;
   logic [4:0]  mem_wb_rd;
   logic [63:0] mem_wb_data;
   logic [63:0] ALU_result_out, WriteData_out, branch_target_out;
   logic [4:0]  rd_out;
   logic        MemtoReg_out, RegWrite_out, MemWrite_out, MemRead_out, flush;

   int n_cmp = 0;
   int n_err = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk(clk), .reset(reset), .PC_In(PC_In), .ReadData1_in(ReadData1_in),
      .ReadData2_in(ReadData2_in), .imm_data_in(imm_data_in), .rs1_in(rs1_in),
      .rs2_in(rs2_in), .rd_in(rd_in), .Funct_in(Funct_in), .ALUOp_in(ALUOp_in),
      .f3_in(f3_in), .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
      .Branch_in(Branch_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
      .ALUSrc_in(ALUSrc_in), .mem_wb_RegWrite(mem_wb_RegWrite), .mem_wb_rd(mem_wb_rd),
      .mem_wb_data(mem_wb_data), .ALU_result_out(ALU_result_out),
      .WriteData_out(WriteData_out), .rd_out(rd_out), .MemtoReg_out(MemtoReg_out),
      .RegWrite_out(RegWrite_out), .MemWrite_out(MemWrite_out), .MemRead_out(MemRead_out),
      .branch_target_out(branch_target_out), .flush(flush)
   );

   // Expected EX/MEM contents as the model sees them
   typedef struct packed {
      logic [63:0] alu;
      logic [63:0] wd;
      logic [4:0]  rd;
      logic        m2r, rw, mw, mr;
      logic [63:0] bt;
      logic        fl;
   } st_t;

   st_t exp_s = '0;

   // Value a register read sees: most recent older producer wins
   function automatic logic [63:0] operand(input st_t s, input logic [4:0] rs, input logic [63:0] rf);
      if (s.rw && s.rd != 5'd0 && s.rd == rs && !s.mr) return s.alu;
      if (mem_wb_RegWrite && mem_wb_rd != 5'd0 && mem_wb_rd == rs) return mem_wb_data;
      return rf;
   endfunction

   function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b);
      int sh;
      logic [63:0] fill;
      sh = int'(b % 64);
      fill = a[63] ? ~({64{1'b1}} >> sh) : 64'd0;
      if (ALUOp_in == 2'b01) return a - b;
      if (ALUOp_in != 2'b10) return a + b;
      case (Funct_in)
         4'b1000: return a - b;
         4'b0111: return a & b;
         4'b0110: return a | b;
         4'b0100: return a ^ b;
         4'b0001: return a << sh;
         4'b0101: return a >> sh;
         4'b1101: return (a >> sh) | fill;
         default: return a + b;
      endcase
   endfunction

   function automatic st_t model_step(input st_t s);
      st_t n;
      logic [63:0] a, b, sa, sb;
      logic cond, ok;
      n = '0;
      if (reset) return n;
      a  = operand(s, rs1_in, ReadData1_in);
      b  = operand(s, rs2_in, ReadData2_in);
      sa = a ^ (64'd1 << 63);
      sb = b ^ (64'd1 << 63);
      case (f3_in)
         3'b000:  cond = (a == b);
         3'b001:  cond = (a != b);
         3'b100:  cond = (sa < sb);
         3'b101:  cond = !(sa < sb);
         3'b110:  cond = (a < b);
         3'b111:  cond = !(a < b);
         default: cond = 1'b0;
      endcase
      ok    = !s.fl;
      n.alu = alu_model(a, ALUSrc_in ? imm_data_in : b);
      n.wd  = b;
      n.rd  = rd_in;
      n.bt  = PC_In + imm_data_in * 64'd2;
      n.m2r = MemtoReg_in & ok;
      n.rw  = RegWrite_in & ok;
      n.mw  = MemWrite_in & ok;
      n.mr  = MemRead_in & ok;
      n.fl  = Branch_in & cond & ok;
      return n;
   endfunction

   // Advance the model on every active edge
   always @(posedge clk) exp_s <= model_step(exp_s);

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] ex);
      n_cmp++;
      if (act !== ex) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, ex);
      end
   endtask

   // Compare every output against the model away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("alu_result", ALU_result_out, exp_s.alu);
         cmp("write_data", WriteData_out, exp_s.wd);
         cmp("rd_out", 64'(rd_out), 64'(exp_s.rd));
         cmp("ctrl", 64'({MemtoReg_out, RegWrite_out, MemWrite_out, MemRead_out}),
             64'({exp_s.m2r, exp_s.rw, exp_s.mw, exp_s.mr}));
         cmp("branch_target", branch_target_out, exp_s.bt);
         cmp("flush", 64'(flush), 64'(exp_s.fl));
      end
   end

   task automatic clr();
      reset = 1'b0; PC_In = 64'd0; ReadData1_in = 64'd0; ReadData2_in = 64'd0;
      imm_data_in = 64'd0; rs1_in = 5'd0; rs2_in = 5'd0; rd_in = 5'd0;
      Funct_in = 4'd0; ALUOp_in = 2'b00; f3_in = 3'b000;
      MemtoReg_in = 1'b0; RegWrite_in = 1'b0; Branch_in = 1'b0;
      MemWrite_in = 1'b0; MemRead_in = 1'b0; ALUSrc_in = 1'b0;
      mem_wb_RegWrite = 1'b0; mem_wb_rd = 5'd0; mem_wb_data = 64'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rtype(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [63:0] d1, input logic [63:0] d2, input logic [3:0] fn);
      clr();
      rs1_in = rs1; rs2_in = rs2; rd_in = rd;
      ReadData1_in = d1; ReadData2_in = d2;
      ALUOp_in = 2'b10; Funct_in = fn; RegWrite_in = 1'b1;
   endtask

   initial begin
      clr();
      reset = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      cmp("reset_alu", ALU_result_out, 64'd0);
      cmp("reset_flush", 64'(flush), 64'd0);

      // ADD R-type
      rtype(5'd10, 5'd11, 5'd3, 64'd5, 64'd7, 4'b0000);
      tick();
      cmp("add_result", ALU_result_out, 64'd12);
      cmp("add_rd", 64'(rd_out), 64'd3);
      cmp("add_rw", 64'(RegWrite_out), 64'd1);

      // EX/MEM beats MEM/WB and stale register data
      rtype(5'd12, 5'd12, 5'd1, 64'd4, 64'd5, 4'b0000);
      tick();
      rtype(5'd1, 5'd1, 5'd2, 64'd0, 64'd0, 4'b0000);
      mem_wb_RegWrite = 1'b1; mem_wb_rd = 5'd1; mem_wb_data = 64'd4;
      tick();
      cmp("fwd_priority_add", ALU_result_out, 64'd18);
      rtype(5'd12, 5'd12, 5'd1, 64'd4, 64'd5, 4'b0000);
      tick();
      rtype(5'd1, 5'd1, 5'd2, 64'd0, 64'd0, 4'b1000);
      mem_wb_RegWrite = 1'b1; mem_wb_rd = 5'd1; mem_wb_data = 64'd4;
      tick();
      cmp("fwd_priority_sub", ALU_result_out, 64'd0);

      // x0 destination is never forwarded
      rtype(5'd12, 5'd12, 5'd0, 64'd4, 64'd5, 4'b0000);
      tick();
      rtype(5'd0, 5'd0, 5'd3, 64'd1, 64'd1, 4'b0000);
      tick();
      cmp("x0_guard", ALU_result_out, 64'd2);

      // Load in EX/MEM: MEM/WB value or register value used instead
      rtype(5'd12, 5'd12, 5'd5, 64'd50, 64'd50, 4'b0000);
      MemRead_in = 1'b1; MemtoReg_in = 1'b1;
      tick();
      rtype(5'd5, 5'd0, 5'd6, 64'd50, 64'd1, 4'b0000);
      mem_wb_RegWrite = 1'b1; mem_wb_rd = 5'd5; mem_wb_data = 64'd7;
      tick();
      cmp("load_guard_memwb", ALU_result_out, 64'd8);
      rtype(5'd12, 5'd12, 5'd5, 64'd50, 64'd50, 4'b0000);
      MemRead_in = 1'b1;
      tick();
      rtype(5'd5, 5'd0, 5'd6, 64'd30, 64'd1, 4'b0000);
      tick();
      cmp("load_guard_rf", ALU_result_out, 64'd31);

      // Taken BEQ, then a would-be-taken instruction that must be squashed
      clr();
      rs1_in = 5'd20; rs2_in = 5'd21; ReadData1_in = 64'h10; ReadData2_in = 64'h10;
      Branch_in = 1'b1; ALUOp_in = 2'b01; f3_in = 3'b000;
      PC_In = 64'h100; imm_data_in = 64'd8;
      tick();
      cmp("beq_flush", 64'(flush), 64'd1);
      cmp("beq_target", branch_target_out, 64'h110);
      clr();
      RegWrite_in = 1'b1; rd_in = 5'd4; Branch_in = 1'b1; f3_in = 3'b000;
      tick();
      cmp("squash_rw", 64'(RegWrite_out), 64'd0);
      cmp("squash_flush", 64'(flush), 64'd0);

      // Signed vs unsigned less-than
      clr();
      ReadData1_in = 64'hFFFF_FFFF_FFFF_FFFF; ReadData2_in = 64'd1;
      Branch_in = 1'b1; ALUOp_in = 2'b01; f3_in = 3'b100;
      tick();
      cmp("blt_taken", 64'(flush), 64'd1);
      clr();
      tick();
      ReadData1_in = 64'hFFFF_FFFF_FFFF_FFFF; ReadData2_in = 64'd1;
      Branch_in = 1'b1; ALUOp_in = 2'b01; f3_in = 3'b110;
      tick();
      cmp("bltu_not_taken", 64'(flush), 64'd0);

      // Reset on the same edge a taken branch would register
      clr();
      ReadData1_in = 64'h33; ReadData2_in = 64'h33; RegWrite_in = 1'b1; rd_in = 5'd7;
      Branch_in = 1'b1; f3_in = 3'b000; PC_In = 64'h200; imm_data_in = 64'd4;
      reset = 1'b1;
      tick();
      cmp("rst_branch_flush", 64'(flush), 64'd0);
      cmp("rst_branch_target", branch_target_out, 64'd0);
      cmp("rst_branch_rw", 64'(RegWrite_out), 64'd0);
      clr();
      tick();
      cmp("rst_branch_flush_after", 64'(flush), 64'd0);

      // Randomized traffic, small register indices to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 99) < 2);
         PC_In        = {$urandom, $urandom};
         ReadData1_in = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 15));
         ReadData2_in = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 15));
         imm_data_in  = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 70));
         rs1_in = 5'($urandom_range(0, 3));
         rs2_in = 5'($urandom_range(0, 3));
         rd_in  = 5'($urandom_range(0, 3));
         Funct_in = 4'($urandom_range(0, 15));
         ALUOp_in = 2'($urandom_range(0, 2));
         f3_in    = 3'($urandom_range(0, 7));
         MemtoReg_in = 1'($urandom_range(0, 1));
         RegWrite_in = 1'($urandom_range(0, 1));
         Branch_in   = ($urandom_range(0, 9) < 3);
         MemWrite_in = 1'($urandom_range(0, 1));
         MemRead_in  = 1'($urandom_range(0, 1));
         ALUSrc_in   = 1'($urandom_range(0, 1));
         mem_wb_RegWrite = 1'($urandom_range(0, 1));
         mem_wb_rd   = 5'($urandom_range(0, 3));
         mem_wb_data = {$urandom, $urandom};
         tick();
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
